// File: rtl/fault_result_monitor.sv
// fault_result_monitor: records a golden output trace, compares fault passes against it, and issues per-fault verdicts
//
// Ports:
//   clk, rst_n                    clock (rising edge) and asynchronous active-low reset
//   pass_start, pass_fid          pulse that opens a pass, and the fault ID sampled with it
//   golden_mode                   sampled with pass_start; 1 = fault-free reference pass
//   smp_valid, smp_data           observed output sample stream
//   pass_end                      pulse that closes the pass (a sample in the same cycle is taken first)
//   vrd_valid, vrd_ready          verdict handshake
//   vrd_fid, vrd_detected         verdict fault ID and detection flag
//   vrd_first_idx                 index of first differing sample (0 when not detected)
//   det_count, undet_count        saturating verdict counters
//   golden_ok                     a golden reference has been stored
//   proto_err                     sticky protocol-violation flag
module fault_result_monitor #(
    parameter int SAMPLE_W    = 1,
    parameter int MAX_SAMPLES = 4,
    parameter int IDX_W       = 3,
    parameter int FID_W       = 17,
    parameter int CNT_W       = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pass_start,
    input  logic [FID_W-1:0]    pass_fid,
    input  logic                golden_mode,
    input  logic                smp_valid,
    input  logic [SAMPLE_W-1:0] smp_data,
    input  logic                pass_end,
    output logic                vrd_valid,
    input  logic                vrd_ready,
    output logic [FID_W-1:0]    vrd_fid,
    output logic                vrd_detected,
    output logic [IDX_W-1:0]    vrd_first_idx,
    output logic [CNT_W-1:0]    det_count,
    output logic [CNT_W-1:0]    undet_count,
    output logic                golden_ok,
    output logic                proto_err
);
    typedef enum logic [1:0] {IDLE, CAPTURE, REPORT} state_t;
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_SAMPLES);
    state_t state, state_nx;
    logic [FID_W-1:0] fid;
    logic is_golden, mism;
    logic [IDX_W-1:0] idx, first_idx, golden_len;
    // Store is sized by the index range so any idx value addresses it exactly;
    // entries at or above MAX_SAMPLES are never written and stay zero.
    logic [SAMPLE_W-1:0] golden [2**IDX_W];
    logic start_ok, take, miss, mism_nx, len_diff, det_nx, hs, err_now;
    logic [IDX_W-1:0] first_nx, cnt, fidx_end;

    assign start_ok = pass_start && (golden_mode || golden_ok);
    assign take     = state == CAPTURE && smp_valid && idx < MAX_IDX;
    assign miss     = take && !is_golden && smp_data != golden[idx];
    assign mism_nx  = mism || miss;
    assign first_nx = (miss && !mism) ? idx : first_idx;
    assign cnt      = take ? idx + IDX_W'(1) : idx;
    assign len_diff = cnt != golden_len;
    assign det_nx   = mism_nx || len_diff;
    // A value mismatch wins; otherwise a length-only difference points at the shorter end.
    assign fidx_end = mism_nx ? first_nx : len_diff ? (cnt < golden_len ? cnt : golden_len) : '0;
    assign hs       = state == REPORT && vrd_ready;
    assign err_now  = (pass_start && (state != IDLE || !start_ok))
                    || (state == CAPTURE && smp_valid && !take);
    assign vrd_valid = state == REPORT;
    assign vrd_fid   = fid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_ok ? CAPTURE : IDLE;
            CAPTURE: state_nx = pass_end ? (is_golden ? IDLE : REPORT) : CAPTURE;
            REPORT:  state_nx = vrd_ready ? IDLE : REPORT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fid           <= '0;
            is_golden     <= 1'b0;
            mism          <= 1'b0;
            idx           <= '0;
            first_idx     <= '0;
            golden_len    <= '0;
            golden_ok     <= 1'b0;
            proto_err     <= 1'b0;
            vrd_detected  <= 1'b0;
            vrd_first_idx <= '0;
            det_count     <= '0;
            undet_count   <= '0;
            for (int i = 0; i < 2**IDX_W; i++) golden[i] <= '0;
        end else begin
            proto_err <= proto_err || err_now;
            if (state == IDLE && start_ok) begin
                fid       <= pass_fid;
                is_golden <= golden_mode;
                idx       <= '0;
                mism      <= 1'b0;
                first_idx <= '0;
            end
            if (take) begin
                idx       <= cnt;
                mism      <= mism_nx;
                first_idx <= first_nx;
                if (is_golden) golden[idx] <= smp_data;
            end
            if (state == CAPTURE && pass_end) begin
                if (is_golden) begin
                    golden_len <= cnt;
                    golden_ok  <= 1'b1;
                end else begin
                    vrd_detected  <= det_nx;
                    vrd_first_idx <= fidx_end;
                end
            end
            if (hs && vrd_detected && det_count != '1) det_count <= det_count + CNT_W'(1);
            if (hs && !vrd_detected && undet_count != '1) undet_count <= undet_count + CNT_W'(1);
        end
    end
endmodule
